// File: rtl/n_term_loopback_matrix_cfg.sv
// North-edge terminator: loops north wire groups back south, with a per-group routing mode
// (mirror, registered mirror, straight, tie-low) loaded through a serial config register.
module n_term_loopback_matrix_cfg #(
  parameter int unsigned W1           = 4,
  parameter int unsigned W2           = 8,
  parameter int unsigned W4           = 16,
  parameter int unsigned DELAY        = 1,
  parameter int unsigned NoConfigBits = 8
) (
  input  logic          UserCLK,
  input  logic          UserRST,
  input  logic          ConfigIn,
  input  logic          ConfigShift,
  input  logic          ConfigLatch,
  output logic          ConfigLoaded,
  output logic          ConfigError,
  input  logic [W1-1:0] N1END,
  input  logic [W2-1:0] N2MID,
  input  logic [W2-1:0] N2END,
  input  logic [W4-1:0] N4END,
  output logic [W1-1:0] S1BEG,
  output logic [W2-1:0] S2BEG,
  output logic [W2-1:0] S2BEGb,
  output logic [W4-1:0] S4BEG
);

  localparam logic [3:0] CntFull = 4'(NoConfigBits);

  logic [NoConfigBits-1:0] shadow_q, shadow_d;
  logic [NoConfigBits-1:0] active_q, active_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    loaded_q, loaded_d;
  logic                    error_q, error_d;

  // Commit decision uses the pre-shift count, but the committed data includes a same-cycle shift.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    loaded_d = 1'b0;
    error_d  = error_q;
    if (ConfigShift) begin
      shadow_d = {shadow_q[NoConfigBits-2:0], ConfigIn};
      if (cnt_q != CntFull) cnt_d = cnt_q + 4'd1;
    end
    if (ConfigLatch) begin
      if (cnt_q == CntFull) begin
        active_d = shadow_d;
        loaded_d = 1'b1;
      end else begin
        error_d = 1'b1;
      end
      cnt_d = ConfigShift ? 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge UserCLK or posedge UserRST) begin
    if (UserRST) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      error_q  <= error_d;
    end
  end

  assign ConfigLoaded = loaded_q;
  assign ConfigError  = error_q;

  logic [W1-1:0] mir1;
  logic [W2-1:0] mir2, mir2b;
  logic [W4-1:0] mir4;

  for (genvar i = 0; i < W1; i++) begin : g_mir1
    assign mir1[i] = N1END[W1-1-i];
  end
  for (genvar i = 0; i < W2; i++) begin : g_mir2
    assign mir2[i]  = N2MID[W2-1-i];
    assign mir2b[i] = N2END[W2-1-i];
  end
  for (genvar i = 0; i < W4; i++) begin : g_mir4
    assign mir4[i] = N4END[W4-1-i];
  end

  // Chains run every cycle regardless of mode so switching to mode 01 shows real history.
  logic [W1-1:0] dly1_q  [DELAY];
  logic [W2-1:0] dly2_q  [DELAY];
  logic [W2-1:0] dly2b_q [DELAY];
  logic [W4-1:0] dly4_q  [DELAY];

  always_ff @(posedge UserCLK or posedge UserRST) begin
    if (UserRST) begin
      for (int unsigned k = 0; k < DELAY; k++) begin
        dly1_q[k]  <= '0;
        dly2_q[k]  <= '0;
        dly2b_q[k] <= '0;
        dly4_q[k]  <= '0;
      end
    end else begin
      dly1_q[0]  <= mir1;
      dly2_q[0]  <= mir2;
      dly2b_q[0] <= mir2b;
      dly4_q[0]  <= mir4;
      for (int unsigned k = 1; k < DELAY; k++) begin
        dly1_q[k]  <= dly1_q[k-1];
        dly2_q[k]  <= dly2_q[k-1];
        dly2b_q[k] <= dly2b_q[k-1];
        dly4_q[k]  <= dly4_q[k-1];
      end
    end
  end

  always_comb begin
    S1BEG = '0;
    unique case (active_q[1:0])
      2'b00:   S1BEG = mir1;
      2'b01:   S1BEG = dly1_q[DELAY-1];
      2'b10:   S1BEG = N1END;
      default: S1BEG = '0;
    endcase
  end

  always_comb begin
    S2BEG = '0;
    unique case (active_q[3:2])
      2'b00:   S2BEG = mir2;
      2'b01:   S2BEG = dly2_q[DELAY-1];
      2'b10:   S2BEG = N2MID;
      default: S2BEG = '0;
    endcase
  end

  always_comb begin
    S2BEGb = '0;
    unique case (active_q[5:4])
      2'b00:   S2BEGb = mir2b;
      2'b01:   S2BEGb = dly2b_q[DELAY-1];
      2'b10:   S2BEGb = N2END;
      default: S2BEGb = '0;
    endcase
  end

  always_comb begin
    S4BEG = '0;
    unique case (active_q[7:6])
      2'b00:   S4BEG = mir4;
      2'b01:   S4BEG = dly4_q[DELAY-1];
      2'b10:   S4BEG = N4END;
      default: S4BEG = '0;
    endcase
  end

endmodule
